// File: rtl/apb_uart_if.sv
// APB3 slave around a compact 8N1 UART with TX/RX FIFOs, baud generator and four byte registers.
// Define APB_UART_IRQ_EN to add the registered irq output.

module apb_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra bit so full and empty stay distinguishable.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (count == '0);
        full     = (count == FULL_CNT);
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

module apb_uart_if #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  rx,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic                  tx
`ifdef APB_UART_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam logic [1:0]            WS     = 2'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] A_DATA = ADDR_WIDTH'(32'h0);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(32'h4);
    localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(32'h8);
    localparam logic [ADDR_WIDTH-1:0] A_INT  = ADDR_WIDTH'(32'hC);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    function automatic logic [13:0] baud_div(input logic [1:0] fi, input logic [2:0] bi);
        logic [13:0] d;
        case (fi)
            2'd0:    d = 14'd434;
            2'd1:    d = 14'd217;
            2'd2:    d = 14'd868;
            default: d = 14'd86;
        endcase
        case ({fi, bi})
            {2'd0, 3'd1}: d = 14'd868;
            {2'd0, 3'd2}: d = 14'd1302;
            {2'd0, 3'd3}: d = 14'd2604;
            {2'd0, 3'd4}: d = 14'd5208;
            {2'd1, 3'd1}: d = 14'd434;
            {2'd1, 3'd2}: d = 14'd651;
            {2'd1, 3'd3}: d = 14'd1302;
            {2'd1, 3'd4}: d = 14'd2604;
            {2'd2, 3'd1}: d = 14'd1736;
            {2'd2, 3'd2}: d = 14'd2604;
            {2'd2, 3'd3}: d = 14'd5208;
            {2'd2, 3'd4}: d = 14'd10416;
            {2'd3, 3'd1}: d = 14'd173;
            {2'd3, 3'd2}: d = 14'd260;
            {2'd3, 3'd3}: d = 14'd520;
            {2'd3, 3'd4}: d = 14'd1041;
            default: ;
        endcase
        return d;
    endfunction

    logic [1:0]  wcnt_q, wcnt_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [1:0]  int_q, int_d;
    logic        rx_err_q, rx_err_d;
    logic        access, wr_commit, rd_commit;
    logic        sel_data, sel_ctrl, sel_stat, sel_int, mapped;
    logic [7:0]  rdata, stat;
    logic        en, tx_en;

    logic        txf_push, txf_pop, txf_empty, txf_full;
    logic [7:0]  txf_dout;
    logic        rxf_push, rxf_pop, rxf_empty, rxf_full;
    logic [7:0]  rxf_dout;

    state_t      tx_state_q, tx_state_d;
    logic [13:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_start, tx_load, tx_bit_end, tx_done_evt, tx_busy;

    state_t      rx_state_q, rx_state_d;
    logic [13:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_fall, rx_bit_end, rx_half_end, rx_done_evt, rx_busy;

    assign en    = ctrl_q[0];
    assign tx_en = ctrl_q[7];

    // APB access phase, register decode and read mux.
    always_comb begin
        access    = PSELx & PENABLE;
        wcnt_d    = '0;
        if (access) wcnt_d = (wcnt_q == WS) ? wcnt_q : wcnt_q + 2'd1;
        PREADY    = access & (wcnt_q == WS);
        wr_commit = PREADY & PWRITE;
        rd_commit = PREADY & ~PWRITE;
        sel_data  = (PADDR == A_DATA);
        sel_ctrl  = (PADDR == A_CTRL);
        sel_stat  = (PADDR == A_STAT);
        sel_int   = (PADDR == A_INT);
        mapped    = sel_data | sel_ctrl | sel_stat | sel_int;
        stat      = {txf_empty, tx_busy, ~txf_full, txf_full,
                     rx_err_q, rx_busy, ~rxf_empty, rxf_empty};
        rdata     = 8'h00;
        if (sel_data)      rdata = rxf_empty ? 8'h00 : rxf_dout;
        else if (sel_ctrl) rdata = ctrl_q;
        else if (sel_stat) rdata = stat;
        else if (sel_int)  rdata = {6'd0, int_q};
        PRDATA    = PREADY ? DATA_WIDTH'(rdata) : '0;
        PSLVERR   = PREADY & ~mapped;
        txf_push  = wr_commit & sel_data;
        rxf_pop   = rd_commit & sel_data;
        ctrl_d    = (wr_commit & sel_ctrl) ? PWDATA[7:0] : ctrl_q;
        // Set events are ORed in after the clear so a coincident set wins.
        int_d     = (int_q & ~((wr_commit & sel_int) ? PWDATA[1:0] : 2'b00))
                  | {tx_done_evt, rx_done_evt};
    end

    apb_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txf (
        .clk(PCLK), .rst_n(PRESETn), .push(txf_push), .din(PWDATA[7:0]),
        .pop(txf_pop), .dout(txf_dout), .empty(txf_empty), .full(txf_full)
    );

    apb_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxf (
        .clk(PCLK), .rst_n(PRESETn), .push(rxf_push), .din(rx_shift_q),
        .pop(rxf_pop), .dout(rxf_dout), .empty(rxf_empty), .full(rxf_full)
    );

    // TX next state: a new frame may start straight out of STOP for back-to-back bytes.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_div_d    = tx_div_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_load     = 1'b0;
        tx_done_evt = 1'b0;
        tx_start    = en & tx_en & ~txf_empty;
        tx_bit_end  = (tx_cnt_q == tx_div_q - 14'd1);
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 14'd1;
        case (tx_state_q)
            S_IDLE:  tx_load = tx_start;
            S_START: if (tx_bit_end) begin
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end
            S_DATA:  if (tx_bit_end) begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
            end
            S_STOP:  if (tx_bit_end) begin
                tx_done_evt = 1'b1;
                tx_state_d  = S_IDLE;
                tx_load     = tx_start;
            end
        endcase
        if (tx_load) begin
            tx_shift_d = txf_dout;
            tx_div_d   = baud_div(ctrl_q[3:2], ctrl_q[6:4]);
            tx_cnt_d   = '0;
            tx_state_d = S_START;
        end
        if (!en) tx_state_d = S_IDLE;
        txf_pop = tx_load;
    end

    always_comb begin
        tx_busy = (tx_state_q != S_IDLE);
        case (tx_state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    // RX next state: centre-sample after a half-bit start check.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_div_d    = rx_div_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_err_d    = rx_err_q;
        rxf_push    = 1'b0;
        rx_done_evt = 1'b0;
        rx_fall     = rx_prev_q & ~rx_s2_q;
        rx_bit_end  = (rx_cnt_q == rx_div_q - 14'd1);
        rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - 14'd1);
        if (rx_state_q != S_IDLE) rx_cnt_d = rx_cnt_q + 14'd1;
        case (rx_state_q)
            S_IDLE:  if (rx_fall) begin
                rx_div_d   = baud_div(ctrl_q[3:2], ctrl_q[6:4]);
                rx_cnt_d   = '0;
                rx_state_d = S_START;
            end
            S_START: if (rx_half_end) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA:  if (rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end
            S_STOP:  if (rx_bit_end) begin
                rx_state_d = S_IDLE;
                if (rx_s2_q & ~rxf_full) begin
                    rxf_push    = 1'b1;
                    rx_done_evt = 1'b1;
                    rx_err_d    = 1'b0;
                end else begin
                    rx_err_d    = 1'b1;
                end
            end
        endcase
        if (!en) begin
            rx_state_d  = S_IDLE;
            rxf_push    = 1'b0;
            rx_done_evt = 1'b0;
            rx_err_d    = rx_err_q;
        end
    end

    always_comb begin
        rx_busy = (rx_state_q != S_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wcnt_q     <= '0;
            ctrl_q     <= '0;
            int_q      <= '0;
            rx_err_q   <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            wcnt_q     <= wcnt_d;
            ctrl_q     <= ctrl_d;
            int_q      <= int_d;
            rx_err_q   <= rx_err_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end

`ifdef APB_UART_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = ctrl_q[0] & ctrl_q[1] & (|int_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_apb_uart_if.sv
// Directed-plus-random bench for apb_uart_if: APB register access, loopback, FIFO limits, RX errors.
module tb_apb_uart_if;
    localparam int CLK_P = 10;
    localparam int WS    = 1;
    localparam logic [3:0] R_DATA = 4'h0, R_CTRL = 4'h4, R_STAT = 4'h8, R_INT = 4'hC;

    logic       PCLK = 1'b0;
    logic       PRESETn, PSELx, PENABLE, PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR, tx_w, rx_w, rx_drv, loop;
`ifdef APB_UART_IRQ_EN
    logic       irq_w;
`endif

    int         n_vec = 0, n_err = 0, bad_waits = 0;
    time        tq[$];
    bit         cap = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rd, b;
    logic       last_err;

    always #(CLK_P/2) PCLK = ~PCLK;
    assign rx_w = loop ? tx_w : rx_drv;
    always @(tx_w) if (cap) tq.push_back($time);

    apb_uart_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WAIT_STATES(WS), .FIFO_DEPTH(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .rx(rx_w), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR), .tx(tx_w)
`ifdef APB_UART_IRQ_EN
        , .irq(irq_w)
`endif
    );

    // Expected STAT from occupancy counts and engine activity.
    function automatic logic [7:0] stat_exp(input int rxn, input bit rxbusy, input bit rxerr,
                                            input int txn, input bit txbusy);
        return {txn == 0, txbusy, txn < 16, txn == 16, rxerr, rxbusy, rxn != 0, rxn == 0};
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic [3:0] a, input logic wr, input logic [7:0] d);
        int w;
        @(posedge PCLK); #1;
        PADDR = a; PWRITE = wr; PWDATA = d; PSELx = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        w = 0;
        while (PREADY !== 1'b1 && w < 8) begin
            @(posedge PCLK); #1;
            w++;
        end
        if (w != WS) bad_waits++;
        last_rd = PRDATA; last_err = PSLVERR;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic poll(input logic [3:0] a, input logic [7:0] mask, input logic [7:0] val,
                        input int max, input string tag);
        int i;
        i = 0;
        do begin
            apb(a, 1'b0, 8'h00);
            i++;
        end while ((last_rd & mask) != val && i < max);
        chk8(tag, last_rd & mask, val);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge PCLK); #1;
            rx_drv = f[i];
            repeat (div - 1) @(posedge PCLK);
        end
        @(posedge PCLK); #1;
        rx_drv = 1'b1;
    endtask

    initial begin
        #(CLK_P * 90000);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0; PADDR = '0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PWDATA = '0; rx_drv = 1'b1; loop = 1'b1;
        repeat (3) @(posedge PCLK); #1;
        chk8("rst_prdata", PRDATA, 8'h00);
        chk8("rst_pins", {5'd0, PREADY, PSLVERR, tx_w}, 8'h01);
        PRESETn = 1'b1;
        apb(R_CTRL, 1'b0, 8'h00); chk8("rst_ctrl", last_rd, 8'h00);
        apb(R_INT, 1'b0, 8'h00);  chk8("rst_int", last_rd, 8'h00);
        apb(R_STAT, 1'b0, 8'h00); chk8("rst_stat", last_rd, stat_exp(0, 0, 0, 0, 0));

        // Loopback 0x55 at 50 MHz / 115200.
        apb(R_CTRL, 1'b1, 8'h81); chk8("ctrl_wr_err", {7'd0, last_err}, 8'h00);
        tq.delete(); cap = 1'b1;
        apb(R_DATA, 1'b1, 8'h55);
        poll(R_INT, 8'hFF, 8'h03, 3000, "int_first");
        cap = 1'b0;
        apb(R_DATA, 1'b0, 8'h00);
        chk8("loop_55", last_rd, 8'h55);
        chk8("loop_55_err", {7'd0, last_err}, 8'h00);
        chk_int("tx_edges", tq.size(), 10);
        for (int i = 1; i < tq.size(); i++)
            chk_int("bit_period", int'((tq[i] - tq[i-1]) / CLK_P), 434);

        // Write-1-to-clear of INT.
        apb(R_INT, 1'b1, 8'h01); apb(R_INT, 1'b0, 8'h00); chk8("int_clr0", last_rd, 8'h02);
        apb(R_INT, 1'b1, 8'h02); apb(R_INT, 1'b0, 8'h00); chk8("int_clr1", last_rd, 8'h00);

        // Random loopback bytes at 10 MHz / 115200 (divisor 86).
        apb(R_CTRL, 1'b1, 8'h8D);
        repeat (5) begin
            b = 8'($urandom);
            apb(R_DATA, 1'b1, b);
            poll(R_INT, 8'hFF, 8'h03, 1000, "int_rand");
            apb(R_DATA, 1'b0, 8'h00); chk8("loop_rand", last_rd, b);
            apb(R_INT, 1'b1, 8'h03);
            apb(R_INT, 1'b0, 8'h00); chk8("int_rand_clr", last_rd, 8'h00);
        end
        apb(R_STAT, 1'b0, 8'h00); chk8("stat_after_rand", last_rd, stat_exp(0, 0, 0, 0, 0));

        // Fill TX FIFO with transmission disabled.
        apb(R_CTRL, 1'b1, 8'h0D);
        tq.delete(); cap = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apb(R_DATA, 1'b1, 8'(i));
            exp_q.push_back(8'(i));
        end
        apb(R_STAT, 1'b0, 8'h00);
        chk8("tx_full_bits", last_rd & 8'h30, 8'h10);
        chk8("stat_full", last_rd, stat_exp(0, 0, 0, 16, 0));
        apb(R_DATA, 1'b1, 8'hAA);
        repeat (50) @(posedge PCLK);
        cap = 1'b0;
        chk_int("tx_held_edges", tq.size(), 0);
        chk8("tx_held", {7'd0, tx_w}, 8'h01);

        // Drain through loopback.
        apb(R_CTRL, 1'b1, 8'h8D);
        while (exp_q.size() > 0) begin
            poll(R_STAT, 8'h02, 8'h02, 600, "rx_ready");
            apb(R_DATA, 1'b0, 8'h00);
            chk8("drain", last_rd, exp_q.pop_front());
        end
        poll(R_STAT, 8'hFF, stat_exp(0, 0, 0, 0, 0), 600, "stat_drained");

        // Unmapped address.
        apb(4'h2, 1'b1, 8'h5A); chk8("unmapped_wr_err", {7'd0, last_err}, 8'h01);
        apb(4'h2, 1'b0, 8'h00); chk8("unmapped_rd_err", {7'd0, last_err}, 8'h01);
        chk8("unmapped_rd_data", last_rd, 8'h00);
        apb(R_CTRL, 1'b0, 8'h00); chk8("ctrl_kept", last_rd, 8'h8D);

        // Externally driven frames: framing error, good frame, glitch.
        loop = 1'b0;
        apb(R_INT, 1'b1, 8'h03);
        apb(R_INT, 1'b0, 8'h00); chk8("int_pre_ferr", last_rd, 8'h00);
        send_frame(8'($urandom), 1'b0, 86);
        repeat (200) @(posedge PCLK);
        apb(R_STAT, 1'b0, 8'h00); chk8("stat_ferr", last_rd, stat_exp(0, 0, 1, 0, 0));
        apb(R_INT, 1'b0, 8'h00);  chk8("int_ferr", last_rd, 8'h00);
        b = 8'($urandom);
        send_frame(b, 1'b1, 86);
        repeat (100) @(posedge PCLK);
        apb(R_STAT, 1'b0, 8'h00); chk8("stat_good", last_rd, stat_exp(1, 0, 0, 0, 0));
        apb(R_INT, 1'b0, 8'h00);  chk8("int_good", last_rd, 8'h01);
        apb(R_DATA, 1'b0, 8'h00); chk8("rx_good", last_rd, b);
        apb(R_DATA, 1'b0, 8'h00); chk8("rx_empty_read", last_rd, 8'h00);
        @(posedge PCLK); #1; rx_drv = 1'b0;
        repeat (10) @(posedge PCLK); #1; rx_drv = 1'b1;
        repeat (200) @(posedge PCLK);
        apb(R_STAT, 1'b0, 8'h00); chk8("stat_glitch", last_rd, stat_exp(0, 0, 0, 0, 0));

        // Reset in the middle of a frame.
        loop = 1'b1;
        apb(R_DATA, 1'b1, 8'h00);
        repeat (20) @(posedge PCLK); #1;
        chk8("tx_midframe", {7'd0, tx_w}, 8'h00);
        PRESETn = 1'b0; #1;
        chk8("tx_reset", {7'd0, tx_w}, 8'h01);
        repeat (2) @(posedge PCLK); #1;
        PRESETn = 1'b1;
        apb(R_CTRL, 1'b0, 8'h00); chk8("ctrl_after_rst", last_rd, 8'h00);
        apb(R_STAT, 1'b0, 8'h00); chk8("stat_after_rst", last_rd, stat_exp(0, 0, 0, 0, 0));

        chk_int("wait_states", bad_waits, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
